// File: rtl/branch_target_lut_if.sv
// Lookup/program bus between the decoder/loader (master) and the branch target table (slave).
interface branch_target_lut_if #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned TARGET_W = 10
);
  logic                Clear;
  logic                Ready;
  logic                WrEn;
  logic [ADDR_W-1:0]   WrAddr;
  logic [TARGET_W-1:0] WrData;
  logic                RdReq;
  logic [ADDR_W-1:0]   RdAddr;
  logic                RelMode;
  logic [TARGET_W-1:0] PC;
  logic                RdValid;
  logic                Hit;
  logic [TARGET_W-1:0] Target;

  modport master (
    output Clear, WrEn, WrAddr, WrData, RdReq, RdAddr, RelMode, PC,
    input  Ready, RdValid, Hit, Target
  );

  modport slave (
    input  Clear, WrEn, WrAddr, WrData, RdReq, RdAddr, RelMode, PC,
    output Ready, RdValid, Hit, Target
  );
endinterface

// File: rtl/branch_target_lut.sv
// Run-time programmable jump-target table: branch pointer -> absolute or PC-relative target,
// one-cycle registered lookup, valid bits swept clear after reset or Clear.
module branch_target_lut #(
  parameter int unsigned         ADDR_W         = 5,
  parameter int unsigned         TARGET_W       = 10,
  parameter logic [TARGET_W-1:0] DEFAULT_TARGET = '0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  branch_target_lut_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic                ready_q, ready_d;
  logic                rd_valid_q, rd_valid_d;
  logic                hit_q, hit_d;
  logic [TARGET_W-1:0] target_q, target_d;

  logic [TARGET_W-1:0] data_q [DEPTH];

  logic                wr_fire_c;
  logic                rd_fire_c;
  logic                entry_hit_c;
  logic [TARGET_W-1:0] entry_data_c;

  // Next-state, table update and lookup result
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    rd_valid_d   = 1'b0;
    hit_d        = hit_q;
    target_d     = target_q;
    wr_fire_c    = 1'b0;
    rd_fire_c    = 1'b0;
    entry_hit_c  = 1'b0;
    entry_data_c = '0;

    case (state_q)
      ST_INIT: begin
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.Clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          wr_fire_c = bus.WrEn;
          rd_fire_c = bus.RdReq;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    if (wr_fire_c) begin
      valid_d[bus.WrAddr] = 1'b1;
    end

    // Write-first bypass when a read targets the entry being written this cycle
    if (wr_fire_c && (bus.WrAddr == bus.RdAddr)) begin
      entry_hit_c  = 1'b1;
      entry_data_c = bus.WrData;
    end else begin
      entry_hit_c  = valid_q[bus.RdAddr];
      entry_data_c = data_q[bus.RdAddr];
    end

    if (rd_fire_c) begin
      rd_valid_d = 1'b1;
      hit_d      = entry_hit_c;
      if (!entry_hit_c) begin
        target_d = DEFAULT_TARGET;
      end else if (bus.RelMode) begin
        // Two's-complement offset: plain modular add gives the signed result
        target_d = bus.PC + entry_data_c;
      end else begin
        target_d = entry_data_c;
      end
    end

    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      valid_q    <= '0;
      ready_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      hit_q      <= 1'b0;
      target_q   <= DEFAULT_TARGET;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      hit_q      <= hit_d;
      target_q   <= target_d;
    end
  end

  // Data array carries no reset; the valid bits gate its contents
  always_ff @(posedge Clk) begin
    if (wr_fire_c) begin
      data_q[bus.WrAddr] <= bus.WrData;
    end
  end

  assign bus.Ready   = ready_q;
  assign bus.RdValid = rd_valid_q;
  assign bus.Hit     = hit_q;
  assign bus.Target  = target_q;

endmodule

// File: tb/tb_branch_target_lut.sv
// Scoreboard bench for branch_target_lut: reference table predicts each lookup at issue time.
module tb_branch_target_lut;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned TARGET_W = 10;
  localparam int unsigned DEPTH    = 2 ** ADDR_W;

  typedef struct packed {
    logic                hit;
    logic [TARGET_W-1:0] target;
  } exp_t;

  logic Clk;
  logic Reset_n;

  branch_target_lut_if #(.ADDR_W(ADDR_W), .TARGET_W(TARGET_W)) bus ();

  branch_target_lut #(
    .ADDR_W        (ADDR_W),
    .TARGET_W      (TARGET_W),
    .DEFAULT_TARGET('0)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  exp_t                sb_q [$];
  logic [TARGET_W-1:0] m_data  [DEPTH];
  logic [DEPTH-1:0]    m_valid = '0;
  logic                m_run   = 1'b0;
  logic                last_hit = 1'b0;
  logic [TARGET_W-1:0] last_tgt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Output monitor: every RdValid must match the oldest outstanding prediction
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (bus.RdValid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_rdvalid", 32'(bus.RdValid), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("hit", 32'(bus.Hit), 32'(e.hit));
        check("target", 32'(bus.Target), 32'(e.target));
      end
    end
  end

  task automatic cyc(input logic wr, input logic [ADDR_W-1:0] wa, input logic [TARGET_W-1:0] wd,
                     input logic rd, input logic [ADDR_W-1:0] ra, input logic rel,
                     input logic [TARGET_W-1:0] pc, input logic clr);
    exp_t                e;
    logic                v;
    logic [TARGET_W-1:0] d;
    @(negedge Clk);
    bus.WrEn = wr; bus.WrAddr = wa; bus.WrData = wd;
    bus.RdReq = rd; bus.RdAddr = ra; bus.RelMode = rel; bus.PC = pc;
    bus.Clear = clr;
    if (m_run && clr) begin
      m_valid = '0;
      m_run   = 1'b0;
    end else if (m_run) begin
      if (rd) begin
        v = (wr && wa == ra) ? 1'b1 : m_valid[ra];
        d = (wr && wa == ra) ? wd : m_data[ra];
        e.hit    = v;
        e.target = !v ? '0 : (rel ? TARGET_W'(pc + d) : d);
        sb_q.push_back(e);
        last_hit = e.hit;
        last_tgt = e.target;
      end
      if (wr) begin
        m_valid[wa] = 1'b1;
        m_data[wa]  = wd;
      end
    end
    @(posedge Clk);
    #1;
    bus.WrEn = 1'b0; bus.RdReq = 1'b0; bus.Clear = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [TARGET_W-1:0] d);
    cyc(1'b1, a, d, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic rel, input logic [TARGET_W-1:0] pc);
    cyc(1'b0, '0, '0, 1'b1, a, rel, pc, 1'b0);
  endtask

  // Counts Ready-low samples from now on; optionally pokes RdReq/WrEn early in INIT
  task automatic wait_ready(input string tag, input logic poke);
    int unsigned cnt = 0;
    while (bus.Ready !== 1'b1 && cnt < 100) begin
      cnt++;
      if (poke && cnt == 1) begin
        bus.RdReq = 1'b1; bus.RdAddr = 5'd3;
        bus.WrEn  = 1'b1; bus.WrAddr = 5'd7; bus.WrData = 10'h3AA;
      end
      if (poke && cnt == 6) begin
        bus.RdReq = 1'b0; bus.WrEn = 1'b0;
      end
      @(posedge Clk);
      #1;
    end
    check(tag, cnt, DEPTH);
    m_run = 1'b1;
  endtask

  task automatic hold_check();
    repeat (2) @(posedge Clk);
    #1;
    check("hold_hit", 32'(bus.Hit), 32'(last_hit));
    check("hold_target", 32'(bus.Target), 32'(last_tgt));
  endtask

  initial begin
    bus.Clear = 1'b0; bus.WrEn = 1'b0; bus.WrAddr = '0; bus.WrData = '0;
    bus.RdReq = 1'b0; bus.RdAddr = '0; bus.RelMode = 1'b0; bus.PC = '0;
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_ready", 32'(bus.Ready), 32'd0);
    check("rst_rdvalid", 32'(bus.RdValid), 32'd0);
    check("rst_hit", 32'(bus.Hit), 32'd0);
    check("rst_target", 32'(bus.Target), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    wait_ready("init_len", 1'b1);

    wr(5'd3, 10'h155);
    rd(5'd3, 1'b0, 10'h000);
    hold_check();
    rd(5'd7, 1'b0, 10'h000);
    rd(5'd7, 1'b1, 10'h123);

    wr(5'd5, 10'h3FC);
    rd(5'd5, 1'b1, 10'h010);
    rd(5'd5, 1'b1, 10'h002);
    wr(5'd6, 10'h008);
    rd(5'd6, 1'b1, 10'h3FC);
    rd(5'd6, 1'b0, 10'h3FC);

    cyc(1'b1, 5'd9, 10'h0AA, 1'b1, 5'd9, 1'b0, 10'h000, 1'b0);
    cyc(1'b1, 5'd10, 10'h005, 1'b1, 5'd10, 1'b1, 10'h100, 1'b0);
    cyc(1'b1, 5'd4, 10'h111, 1'b1, 5'd3, 1'b0, 10'h000, 1'b0);
    rd(5'd4, 1'b0, 10'h000);
    wr(5'd3, 10'h2AB);
    rd(5'd3, 1'b0, 10'h000);
    hold_check();

    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 10'($urandom),
          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), 10'($urandom), 1'b0);
    end

    // Clear with same-cycle write/read: both must be dropped
    cyc(1'b1, 5'd12, 10'h0FF, 1'b1, 5'd3, 1'b0, 10'h000, 1'b1);
    wait_ready("clear_len", 1'b0);
    rd(5'd3, 1'b0, 10'h000);
    rd(5'd12, 1'b0, 10'h000);
    wr(5'd8, 10'h0C3);
    rd(5'd8, 1'b0, 10'h000);

    cyc(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    m_valid = '0;
    wait_ready("reinit_len", 1'b0);
    rd(5'd8, 1'b0, 10'h000);
    rd(5'd5, 1'b1, 10'h010);

    repeat (3) @(posedge Clk);
    #2;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
